// File: rtl/draw_arbiter.sv
// rtl/draw_arbiter.sv - two-requester round-robin arbiter in front of the VGA box/pixel plotter
// Optional WAIT-state timeout enabled by defining DRAW_ARB_TIMEOUT_EN.
module draw_arbiter #(
    parameter logic [19:0] TIMEOUT_CYCLES = 20'd153600
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       req1,
    input  logic       req2,
    input  logic [7:0] x1,
    input  logic [7:0] y1,
    input  logic [7:0] x2,
    input  logic [7:0] y2,
    input  logic [2:0] colour1,
    input  logic [2:0] colour2,
    input  logic       full1,
    input  logic       full2,
    output logic       ack1,
    output logic       ack2,
    output logic [7:0] plot_x,
    output logic [7:0] plot_y,
    output logic [2:0] plot_colour,
    output logic       plot_full,
    output logic       plot_go,
    input  logic       plot_done,
    output logic [1:0] grant,
    output logic       busy,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t     state, state_next;
    logic [1:0] owner, owner_next;
    logic       last_served_2;
    logic       pick1;
    logic       wait_expired;

    // On a tie the requester that was not served last wins.
    always_comb begin
        pick1 = 1'b0;
        if (req1 && req2) begin
            pick1 = last_served_2;
        end else begin
            pick1 = req1;
        end
    end

    always_comb begin
        state_next = state;
        owner_next = owner;
        case (state)
            S_IDLE: begin
                if (req1 || req2) begin
                    state_next = S_ISSUE;
                    owner_next = pick1 ? 2'b01 : 2'b10;
                end
            end
            S_ISSUE: state_next = S_WAIT;
            S_WAIT: begin
                if (plot_done || wait_expired) begin
                    state_next = S_ACK;
                end
            end
            S_ACK:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state         <= S_IDLE;
            owner         <= 2'b00;
            last_served_2 <= 1'b1;
            plot_x        <= 8'd0;
            plot_y        <= 8'd0;
            plot_colour   <= 3'd0;
            plot_full     <= 1'b0;
        end else begin
            state <= state_next;
            owner <= owner_next;
            if (state == S_IDLE && state_next == S_ISSUE) begin
                plot_x      <= pick1 ? x1 : x2;
                plot_y      <= pick1 ? y1 : y2;
                plot_colour <= pick1 ? colour1 : colour2;
                plot_full   <= pick1 ? full1 : full2;
            end
            if (state == S_ACK) begin
                last_served_2 <= owner[1];
            end
        end
    end

    assign busy    = (state != S_IDLE);
    assign plot_go = (state == S_ISSUE);
    assign grant   = busy ? owner : 2'b00;
    assign ack1    = (state == S_ACK) && owner[0];
    assign ack2    = (state == S_ACK) && owner[1];

`ifdef DRAW_ARB_TIMEOUT_EN
    logic [19:0] wait_cnt;
    logic        timeout_flag;

    // Counter restarts on every WAIT entry and parks once it has expired.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            wait_cnt     <= 20'd0;
            timeout_flag <= 1'b0;
        end else begin
            if (state == S_ISSUE) begin
                wait_cnt <= 20'd0;
            end else if (state == S_WAIT && !wait_expired) begin
                wait_cnt <= wait_cnt + 20'd1;
            end
            if (state == S_WAIT && wait_expired && !plot_done) begin
                timeout_flag <= 1'b1;
            end
        end
    end

    assign wait_expired = (wait_cnt == TIMEOUT_CYCLES);
    assign timeout_err  = timeout_flag;
`else
    assign wait_expired = 1'b0;
    assign timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_draw_arbiter.sv
// tb/tb_draw_arbiter.sv - scoreboard bench for draw_arbiter
module tb_draw_arbiter;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       req1 = 1'b0, req2 = 1'b0;
    logic [7:0] x1 = 8'd0, y1 = 8'd0, x2 = 8'd0, y2 = 8'd0;
    logic [2:0] colour1 = 3'd0, colour2 = 3'd0;
    logic       full1 = 1'b0, full2 = 1'b0;
    logic       plot_done = 1'b0;
    logic       ack1, ack2, plot_full, plot_go, busy, timeout_err;
    logic [7:0] plot_x, plot_y;
    logic [2:0] plot_colour;
    logic [1:0] grant;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic [1:0] g;
        logic [7:0] x;
        logic [7:0] y;
        logic [2:0] c;
        logic       f;
    } exp_t;

    exp_t       go_q[$];
    logic [1:0] ack_q[$];

    draw_arbiter #(.TIMEOUT_CYCLES(20'd10)) dut (
        .clock(clock), .resetn(resetn),
        .req1(req1), .req2(req2),
        .x1(x1), .y1(y1), .x2(x2), .y2(y2),
        .colour1(colour1), .colour2(colour2),
        .full1(full1), .full2(full2),
        .ack1(ack1), .ack2(ack2),
        .plot_x(plot_x), .plot_y(plot_y),
        .plot_colour(plot_colour), .plot_full(plot_full),
        .plot_go(plot_go), .plot_done(plot_done),
        .grant(grant), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] g, input logic [7:0] x, input logic [7:0] y,
                                input logic [2:0] c, input logic f);
        exp_t e;
        e.g = g; e.x = x; e.y = y; e.c = c; e.f = f;
        return e;
    endfunction

    // Monitor: every plot_go and every ack is matched against the scoreboard.
    always @(negedge clock) begin
        exp_t e;
        logic [1:0] a;
        if (plot_go) begin
            if (go_q.size() == 0) begin
                chk("unexpected_plot_go", 32'd1, 32'd0);
            end else begin
                e = go_q.pop_front();
                chk("grant", {30'd0, grant}, {30'd0, e.g});
                chk("plot_x", {24'd0, plot_x}, {24'd0, e.x});
                chk("plot_y", {24'd0, plot_y}, {24'd0, e.y});
                chk("plot_colour", {29'd0, plot_colour}, {29'd0, e.c});
                chk("plot_full", {31'd0, plot_full}, {31'd0, e.f});
            end
        end
        if (ack1 || ack2) begin
            if (ack_q.size() == 0) begin
                chk("unexpected_ack", {30'd0, ack2, ack1}, 32'd0);
            end else begin
                a = ack_q.pop_front();
                chk("ack", {30'd0, ack2, ack1}, {30'd0, a});
                chk("grant_in_ack", {30'd0, grant}, {30'd0, a});
            end
        end
    end

    task automatic do_reset(input bit check);
        @(posedge clock); #1 resetn = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        if (check) begin
            chk("rst_grant", {30'd0, grant}, 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_plot_x", {24'd0, plot_x}, 32'd0);
            chk("rst_plot_y", {24'd0, plot_y}, 32'd0);
            chk("rst_colour_full", {28'd0, plot_colour, plot_full}, 32'd0);
            chk("rst_go_acks", {29'd0, plot_go, ack2, ack1}, 32'd0);
            chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        end
        @(posedge clock); #1 resetn = 1'b1;
    endtask

    // Returns at the negedge of the first WAIT cycle.
    task automatic wait_go();
        int n = 0;
        @(negedge clock);
        while (!plot_go && n < 30) begin
            @(negedge clock);
            n++;
        end
        chk("plot_go_seen", {31'd0, plot_go}, 32'd1);
        if (plot_go) begin
            @(negedge clock);
            chk("plot_go_single", {31'd0, plot_go}, 32'd0);
            chk("busy_in_wait", {31'd0, busy}, 32'd1);
        end
    endtask

    // plot_done is raised d cycles after the plot_go cycle (d >= 2); ack must follow next cycle.
    task automatic finish(input int d);
        repeat (d - 1) @(posedge clock);
        #1 plot_done = 1'b1;
        @(posedge clock); #1 plot_done = 1'b0;
        @(negedge clock);
        chk("ack_latency", {31'd0, ack1 | ack2}, 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        x2 = 8'd200; y2 = 8'd100; colour2 = 3'b011; full2 = 1'b0;
        do_reset(1'b1);

        // single request from requester 1
        x1 = 8'd20; y1 = 8'd40; colour1 = 3'b100; full1 = 1'b1;
        go_q.push_back(mk(2'b01, 8'd20, 8'd40, 3'b100, 1'b1));
        ack_q.push_back(2'b01);
        @(posedge clock); #1 req1 = 1'b1;
        wait_go();
        finish(5);
        @(posedge clock); #1 req1 = 1'b0;

        // both requesting continuously after reset: 1,2,1,2
        do_reset(1'b0);
        x1 = 8'd1; y1 = 8'd2; colour1 = 3'b001; full1 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            go_q.push_back(mk(2'b01, 8'd1, 8'd2, 3'b001, 1'b0));
            go_q.push_back(mk(2'b10, 8'd200, 8'd100, 3'b011, 1'b0));
            ack_q.push_back(2'b01);
            ack_q.push_back(2'b10);
        end
        @(posedge clock); #1 req1 = 1'b1; req2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_go();
            finish(3);
        end
        @(posedge clock); #1 req1 = 1'b0; req2 = 1'b0;

        // requester 2 alone three times; requester 1 inputs wiggle meanwhile
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1 x2 = 8'(10 + 2 * i); y2 = 8'(11 + 2 * i); full2 = i[0];
            go_q.push_back(mk(2'b10, 8'(10 + 2 * i), 8'(11 + 2 * i), 3'b011, i[0]));
            ack_q.push_back(2'b10);
            req2 = 1'b1;
            wait_go();
            x1 = 8'hEE;
            finish(2);
            @(posedge clock); #1 req2 = 1'b0;
        end

        // req1 dropped and x1 changed mid-transfer
        x1 = 8'd50; y1 = 8'd60; colour1 = 3'b110; full1 = 1'b1;
        go_q.push_back(mk(2'b01, 8'd50, 8'd60, 3'b110, 1'b1));
        ack_q.push_back(2'b01);
        @(posedge clock); #1 req1 = 1'b1;
        wait_go();
        @(posedge clock); #1 req1 = 1'b0; x1 = 8'd99; y1 = 8'd77;
        @(negedge clock);
        chk("plot_x_held", {24'd0, plot_x}, 32'd50);
        chk("plot_y_held", {24'd0, plot_y}, 32'd60);
        finish(4);

        // reset during WAIT, then a stray plot_done
        x1 = 8'd33; y1 = 8'd34; colour1 = 3'b010; full1 = 1'b0;
        go_q.push_back(mk(2'b01, 8'd33, 8'd34, 3'b010, 1'b0));
        @(posedge clock); #1 req1 = 1'b1;
        wait_go();
        @(posedge clock); #1 resetn = 1'b0; req1 = 1'b0;
        @(posedge clock); #1 resetn = 1'b1; plot_done = 1'b1;
        @(posedge clock); #1 plot_done = 1'b0;
        @(negedge clock);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_grant", {30'd0, grant}, 32'd0);
        chk("abort_plot_x", {24'd0, plot_x}, 32'd0);
        chk("abort_acks", {30'd0, ack2, ack1}, 32'd0);
        repeat (3) @(negedge clock);
        go_q.push_back(mk(2'b01, 8'd33, 8'd34, 3'b010, 1'b0));
        ack_q.push_back(2'b01);
        @(posedge clock); #1 req1 = 1'b1;
        wait_go();
        finish(2);
        @(posedge clock); #1 req1 = 1'b0;

        // plot_done never arrives
        x1 = 8'd7; y1 = 8'd8; colour1 = 3'b111; full1 = 1'b1;
        go_q.push_back(mk(2'b01, 8'd7, 8'd8, 3'b111, 1'b1));
        @(posedge clock); #1 req1 = 1'b1;
        wait_go();
`ifdef DRAW_ARB_TIMEOUT_EN
        begin
            int n = 0;
            ack_q.push_back(2'b01);
            while (!ack1 && n < 30) begin
                @(negedge clock);
                n++;
            end
            chk("timeout_ack_delay", n, 32'd11);
            @(posedge clock); #1 req1 = 1'b0;
            repeat (5) @(negedge clock);
            chk("timeout_err_sticky", {31'd0, timeout_err}, 32'd1);
            do_reset(1'b1);
        end
`else
        repeat (1000) @(negedge clock);
        chk("no_timeout_busy", {31'd0, busy}, 32'd1);
        chk("no_timeout_err", {31'd0, timeout_err}, 32'd0);
        ack_q.push_back(2'b01);
        finish(2);
        @(posedge clock); #1 req1 = 1'b0;
`endif

        repeat (4) @(negedge clock);
        chk("go_queue_empty", go_q.size(), 32'd0);
        chk("ack_queue_empty", ack_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
